rtc_hms_counter: RTL
====================

# rtc_hms_counter

Parametrised time-of-day counter. It keeps hours, minutes and seconds as BCD, selects 12 h or 24 h display at run time, supports per-field setting without carry, and raises a single-cycle minute alarm. It succeeds the HH:MM-only display counter. Its BCD digit outputs drive the seven-segment scan block directly, and it has one clock domain.

## Interface
Parameters:
- DIV, 50_000_000: mclk cycles per second. Must be ≥ 2.
- CNT_W, $clog2(DIV): prescaler width. Derived; do not override.

Ports:
- mclk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- mode_12h, input, 1: 1 selects 12 h display, 0 selects 24 h. Affects display only.
- set_en, input, 1: 1 enters set mode, 0 selects run mode.
- inc, input, 3: single-cycle increment pulses. Bit 0 is seconds, bit 1 minutes, bit 2 hours. Honoured only in set mode.
- alarm_en, input, 1: alarm enable.
- alarm_time, input, 14: alarm time as 24 h BCD, laid out {h_ten[1:0], h_one[3:0], m_ten[2:0], m_one[3:0]}.
- hour_ten, output, 2: display hour tens.
- hour_one, output, 4: display hour units.
- min_ten, output, 3: minute tens.
- min_one, output, 4: minute units.
- sec_ten, output, 3: second tens.
- sec_one, output, 4: second units.
- pm, output, 1: 1 when the internal hour is 12–23. Valid in both display modes.
- tick_1hz, output, 1: one-cycle pulse at each second boundary while running.
- alarm_hit, output, 1: one-cycle registered alarm pulse.

## Operation
- State is a prescaler, 0..DIV-1, plus an internal 24 h BCD time, 00:00:00..23:59:59.
- Run mode (set_en = 0):
  - The prescaler increments every cycle and wraps from DIV-1 to 0.
  - tick_1hz = (prescaler == DIV-1) && !set_en. This is combinational from the registered count.
  - On a tick, seconds advance by 1. A carry into minutes occurs at 59→00; a carry into hours occurs at 59:59→00:00.
  - Hours go 23:59:59→00:00:00.
- Set mode (set_en = 1):
  - The prescaler is held at 0 and no ticks occur.
  - inc[k] adds 1 to field k only. Seconds and minutes wrap 59→00; hours wrap 23→00. No carry propagates to other fields.
  - Several inc bits set in the same cycle are all applied.
  - inc is ignored in run mode.
- Leaving set mode: the prescaler starts from 0, so the first tick comes DIV cycles after the first cycle with set_en = 0.
- BCD rule: units count 0–9; the tens digit increments on a units wrap. Hour 23 wraps to 00, never 24. No illegal BCD state is reachable.
- Display mapping:
  - 24 h mode: display hour = internal hour.
  - 12 h mode: 00→12, 01–11 unchanged, 12→12, 13–23 → 01–11.
  - The mapping is combinational, so a mode change is visible in the same cycle.
- Alarm:
  - alarm_hit is registered.
  - It is set for one cycle when a tick moves the time to alarm_time with seconds 00 and alarm_en = 1.
  - The compare uses the next-state time and the internal 24 h format.
  - Set-mode changes never trigger the alarm.
  - alarm_time values that are not legal BCD never match.

## Timing
- Reset values: prescaler 0 and time 00:00:00.
  - Display outputs: hour_ten = 0, hour_one = 0, min = 00, sec = 00 in 24 h mode. In 12 h mode the display shows 12, i.e. hour_ten = 1 and hour_one = 2.
  - pm = 0, tick_1hz = 0, alarm_hit = 0.
- Counter latency: the time registers update on the edge that ends the cycle in which tick_1hz is high. Outputs show the new time one cycle after tick_1hz.
- alarm_hit is high in the same cycle that the outputs first show the matching HH:MM:00.
- Reset asserted mid-operation clears everything immediately, including a pending alarm pulse. Counting resumes DIV cycles after rst deasserts.
- set_en rising in the same cycle as a would-be tick: set mode wins, so there is no tick.

## Structure
- Package rtc_pkg holds:
  - constants SEC_MOD = 60, MIN_MOD = 60, HOUR_MOD = 24;
  - the field index constants F_SEC = 0, F_MIN = 1, F_HOUR = 2;
  - the alarm_time bit-slice positions.
- Sub-module bcd_mod_counter:
  - Parameters: MOD and TEN_W.
  - Inputs: en, inc_only. Outputs: tens, units, and a combinational carry_out = en && at MOD-1.
  - Three instances: seconds, minutes and hours. A carry chains to the next instance's en only in run mode.
- The top level contains the prescaler, set/inc gating, 12 h mapping and alarm compare register.

## Test plan
All scenarios use DIV = 4.
1. Reset: assert rst mid-count. All outputs go to the reset values in the same cycle. After release, the first tick_1hz comes in cycle 4 and sec_one = 1 the cycle after.
2. Rollover: preset 23:59:59 via set mode, then run. One tick later the outputs show 00:00:00, pm falls 1→0, and there is exactly one tick pulse.
3. 12 h mapping with mode_12h = 1:
   - internal 00 → displays 12, pm = 0;
   - internal 12 → 12, pm = 1;
   - internal 13 → 01, pm = 1;
   - toggling mode_12h changes the display in the same cycle.
4. Set mode: at 10:59:59 pulse inc = 3'b111. The time becomes 11:00:00 field-wise with no carry, and no tick_1hz occurs while set_en = 1. Re-entering run mode gives the first tick after 4 cycles.
5. Alarm: alarm_time = 07:30, time 07:29:59, alarm_en = 1. alarm_hit pulses for exactly one cycle, coincident with 07:30:00.
   - Setting 07:30:00 through set mode gives no pulse.
   - With alarm_en = 0 there is no pulse.
6. Alarm with an illegal BCD alarm_time = 2'b10, 4'hA, … never fires over a full simulated day.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants for the HH:MM:SS time-of-day counter.
//   - field moduli and the bit index of each field in the inc vector
//   - bit positions of the digits packed into alarm_time
//   - hour_to_12h: maps a 24 h BCD hour onto its 12 h display form
package rtc_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int F_SEC  = 0;
  localparam int F_MIN  = 1;
  localparam int F_HOUR = 2;

  // alarm_time = {spare, h_ten[1:0], h_one[3:0], m_ten[2:0], m_one[3:0]}
  localparam int AL_MIN_ONE_LSB  = 0;
  localparam int AL_MIN_TEN_LSB  = 4;
  localparam int AL_HOUR_ONE_LSB = 7;
  localparam int AL_HOUR_TEN_LSB = 11;
  localparam int AL_SPARE_BIT    = 13;

  // Returns {ten[1:0], one[3:0]} of the 12 h display hour.
  function automatic logic [5:0] hour_to_12h(input logic [1:0] ten,
                                             input logic [3:0] one);
    logic [4:0] h;
    logic [4:0] d;
    h = 5'(ten) * 5'd10 + 5'(one);
    if (h == 5'd0)       d = 5'd12;
    else if (h > 5'd12)  d = h - 5'd12;
    else                 d = h;
    if (d >= 5'd10) return {2'd1, 4'(d - 5'd10)};
    else            return {2'd0, 4'(d)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MOD-1 back to 00.
//   clk, rst   : clock, asynchronous active-high reset (clears to 00)
//   en         : chained increment; may produce carry_out
//   inc_only   : isolated increment (set mode); never produces carry_out
//   tens/units : current digits
//   tens_nxt/units_nxt : digits this counter will hold after the edge
//   carry_out  : en && count is at MOD-1 (combinational)
module bcd_mod_counter #(
  parameter int MOD   = 60,
  parameter int TEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc_only,
  output logic [TEN_W-1:0] tens,
  output logic [3:0]       units,
  output logic [TEN_W-1:0] tens_nxt,
  output logic [3:0]       units_nxt,
  output logic             carry_out
);

  localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'((MOD - 1) / 10);
  localparam logic [3:0]       ONE_MAX = 4'((MOD - 1) % 10);

  logic [TEN_W-1:0] tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             at_max;

  assign at_max    = (tens_q == TEN_MAX) && (units_q == ONE_MAX);
  assign carry_out = en && at_max;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (en || inc_only) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 1'b1;
        units_d = '0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens      = tens_q;
  assign units     = units_q;
  assign tens_nxt  = tens_d;
  assign units_nxt = units_d;

endmodule

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter: BCD HH:MM:SS with run/set modes, 12/24 h display
// and a one-cycle registered minute alarm.
//   mclk, rst        : clock, asynchronous active-high reset
//   mode_12h         : 1 = 12 h display, 0 = 24 h (display only)
//   set_en, inc[2:0] : set mode and per-field increment pulses {h,m,s}
//   alarm_en, alarm_time : alarm enable and 24 h BCD HH:MM
//   hour_*/min_*/sec_* : display digits
//   pm, tick_1hz, alarm_hit : status outputs
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int DIV   = 50_000_000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        mode_12h,
  input  logic        set_en,
  input  logic [2:0]  inc,
  input  logic        alarm_en,
  input  logic [13:0] alarm_time,
  output logic [1:0]  hour_ten,
  output logic [3:0]  hour_one,
  output logic [2:0]  min_ten,
  output logic [3:0]  min_one,
  output logic [2:0]  sec_ten,
  output logic [3:0]  sec_one,
  output logic        pm,
  output logic        tick_1hz,
  output logic        alarm_hit
);

  logic [CNT_W-1:0] pre_q, pre_d;
  logic             pre_wrap;
  logic             run;

  assign run      = !set_en;
  assign pre_wrap = (pre_q == CNT_W'(DIV - 1));
  assign tick_1hz = pre_wrap && run;

  // Held at 0 in set mode so the first tick after leaving comes a full
  // second later.
  always_comb begin
    pre_d = pre_q + 1'b1;
    if (set_en || pre_wrap) pre_d = '0;
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  logic [2:0] s_ten, s_ten_nxt, m_ten, m_ten_nxt;
  logic [3:0] s_one, s_one_nxt, m_one, m_one_nxt, h_one, h_one_nxt;
  logic [1:0] h_ten, h_ten_nxt;
  logic       s_carry, m_carry, hour_carry_unused;

  bcd_mod_counter #(.MOD(SEC_MOD), .TEN_W(3)) u_sec (
    .clk(mclk), .rst(rst),
    .en(tick_1hz), .inc_only(set_en && inc[F_SEC]),
    .tens(s_ten), .units(s_one),
    .tens_nxt(s_ten_nxt), .units_nxt(s_one_nxt),
    .carry_out(s_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MOD), .TEN_W(3)) u_min (
    .clk(mclk), .rst(rst),
    .en(s_carry && run), .inc_only(set_en && inc[F_MIN]),
    .tens(m_ten), .units(m_one),
    .tens_nxt(m_ten_nxt), .units_nxt(m_one_nxt),
    .carry_out(m_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD), .TEN_W(2)) u_hour (
    .clk(mclk), .rst(rst),
    .en(m_carry && run), .inc_only(set_en && inc[F_HOUR]),
    .tens(h_ten), .units(h_one),
    .tens_nxt(h_ten_nxt), .units_nxt(h_one_nxt),
    .carry_out(hour_carry_unused)
  );

  // Compare against the post-tick time so the pulse lines up with the
  // first cycle showing HH:MM:00. Illegal BCD in alarm_time can never
  // equal a reachable time; a set spare bit is likewise never matched.
  logic alarm_match;
  logic alarm_q, alarm_d;

  assign alarm_match =
      !alarm_time[AL_SPARE_BIT]
      && (h_ten_nxt == alarm_time[AL_HOUR_TEN_LSB +: 2])
      && (h_one_nxt == alarm_time[AL_HOUR_ONE_LSB +: 4])
      && (m_ten_nxt == alarm_time[AL_MIN_TEN_LSB +: 3])
      && (m_one_nxt == alarm_time[AL_MIN_ONE_LSB +: 4])
      && (s_ten_nxt == 3'd0) && (s_one_nxt == 4'd0);

  assign alarm_d = tick_1hz && alarm_en && alarm_match;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= alarm_d;
  end

  assign alarm_hit = alarm_q;

  logic [5:0] h12;
  assign h12 = hour_to_12h(h_ten, h_one);

  assign hour_ten = mode_12h ? h12[5:4] : h_ten;
  assign hour_one = mode_12h ? h12[3:0] : h_one;
  assign min_ten  = m_ten;
  assign min_one  = m_one;
  assign sec_ten  = s_ten;
  assign sec_one  = s_one;
  assign pm       = (h_ten == 2'd2) || ((h_ten == 2'd1) && (h_one >= 4'd2));

endmodule
